// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and the data memory.
//   o_Mem_Req/o_Mem_Write/o_Mem_Addr/o_Mem_Byte_En/o_Mem_Wdata : driven by the LSU
//   i_Mem_Ready  : memory accepts the request in this cycle
//   i_Mem_Rvalid : read data is valid; i_Mem_Rdata carries the read word
// master = LSU side, slave = memory side.
interface load_store_unit_if #(parameter int XLEN = 32);
    logic              o_Mem_Req;
    logic              o_Mem_Write;
    logic [XLEN-1:0]   o_Mem_Addr;
    logic [XLEN/8-1:0] o_Mem_Byte_En;
    logic [XLEN-1:0]   o_Mem_Wdata;
    logic              i_Mem_Ready;
    logic              i_Mem_Rvalid;
    logic [XLEN-1:0]   i_Mem_Rdata;

    modport master (
        output o_Mem_Req, o_Mem_Write, o_Mem_Addr, o_Mem_Byte_En, o_Mem_Wdata,
        input  i_Mem_Ready, i_Mem_Rvalid, i_Mem_Rdata
    );

    modport slave (
        input  o_Mem_Req, o_Mem_Write, o_Mem_Addr, o_Mem_Byte_En, o_Mem_Wdata,
        output i_Mem_Ready, i_Mem_Rvalid, i_Mem_Rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage of the RV32I core. Runs one data-memory transaction per
// instruction and returns the extended load result.
//   i_Clk, i_Reset_N   : clock, asynchronous active-low reset
//   i_Start            : request strobe, only looked at while idle
//   i_Load_Store_Type  : 0 NONE,1 LB,2 LH,3 LW,4 LBU,5 LHU,6 SB,7 SH,8 SW (others NONE)
//   i_Addr             : effective byte address
//   i_Store_Data       : rs2 store data (low bits)
//   o_Busy             : high whenever not idle
//   o_Done             : one-cycle completion pulse
//   o_Load_Data        : extended load result, held until the next load completes
//   o_Misaligned       : with o_Done, the access was aborted for alignment
//   mem                : data-memory bus (master side)
// All outputs are registered.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_Clk,
    input  logic            i_Reset_N,
    input  logic            i_Start,
    input  logic [4:0]      i_Load_Store_Type,
    input  logic [XLEN-1:0] i_Addr,
    input  logic [XLEN-1:0] i_Store_Data,
    output logic            o_Busy,
    output logic            o_Done,
    output logic [XLEN-1:0] o_Load_Data,
    output logic            o_Misaligned,
    load_store_unit_if.master mem
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t            r_State;
    size_t             r_Size;
    logic              r_Signed;
    logic [1:0]        r_Off;
    logic              r_Busy, r_Done, r_Misaligned;
    logic [XLEN-1:0]   r_Load_Data;
    logic              r_Mem_Req, r_Mem_Write;
    logic [XLEN-1:0]   r_Mem_Addr, r_Mem_Wdata;
    logic [XLEN/8-1:0] r_Mem_Byte_En;

    // Decode of the incoming request (only meaningful in IDLE with i_Start).
    logic              w_Is_Load, w_Is_Store, w_Signed, w_Misaligned;
    size_t             w_Size;
    logic [XLEN/8-1:0] w_Byte_En;
    logic [XLEN-1:0]   w_Wdata;

    always_comb begin
        w_Is_Load  = 1'b0;
        w_Is_Store = 1'b0;
        w_Signed   = 1'b0;
        w_Size     = SZ_W;
        case (i_Load_Store_Type)
            5'd1: begin w_Is_Load  = 1'b1; w_Size = SZ_B; w_Signed = 1'b1; end
            5'd2: begin w_Is_Load  = 1'b1; w_Size = SZ_H; w_Signed = 1'b1; end
            5'd3: begin w_Is_Load  = 1'b1; w_Size = SZ_W; end
            5'd4: begin w_Is_Load  = 1'b1; w_Size = SZ_B; end
            5'd5: begin w_Is_Load  = 1'b1; w_Size = SZ_H; end
            5'd6: begin w_Is_Store = 1'b1; w_Size = SZ_B; end
            5'd7: begin w_Is_Store = 1'b1; w_Size = SZ_H; end
            5'd8: begin w_Is_Store = 1'b1; w_Size = SZ_W; end
            default: ;
        endcase

        w_Misaligned = (w_Size == SZ_H && i_Addr[0]) ||
                       (w_Size == SZ_W && i_Addr[1:0] != 2'b00);

        // Store data is replicated across all lanes so the memory can pick
        // whichever lanes the byte enables select.
        case (w_Size)
            SZ_B: begin
                w_Byte_En = 4'b0001 << i_Addr[1:0];
                w_Wdata   = {4{i_Store_Data[7:0]}};
            end
            SZ_H: begin
                w_Byte_En = i_Addr[1] ? 4'b1100 : 4'b0011;
                w_Wdata   = {2{i_Store_Data[15:0]}};
            end
            default: begin
                w_Byte_En = 4'b1111;
                w_Wdata   = i_Store_Data;
            end
        endcase
    end

    // Lane extraction and extension of the returned read word.
    logic [7:0]      w_Byte;
    logic [15:0]     w_Half;
    logic [XLEN-1:0] w_Load_Ext;

    always_comb begin
        w_Byte = mem.i_Mem_Rdata[{r_Off, 3'b000} +: 8];
        w_Half = mem.i_Mem_Rdata[{r_Off[1], 4'b0000} +: 16];
        case (r_Size)
            SZ_B:    w_Load_Ext = {{(XLEN-8){r_Signed & w_Byte[7]}}, w_Byte};
            SZ_H:    w_Load_Ext = {{(XLEN-16){r_Signed & w_Half[15]}}, w_Half};
            default: w_Load_Ext = mem.i_Mem_Rdata;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            r_State       <= S_IDLE;
            r_Size        <= SZ_W;
            r_Signed      <= 1'b0;
            r_Off         <= '0;
            r_Busy        <= 1'b0;
            r_Done        <= 1'b0;
            r_Misaligned  <= 1'b0;
            r_Load_Data   <= '0;
            r_Mem_Req     <= 1'b0;
            r_Mem_Write   <= 1'b0;
            r_Mem_Addr    <= '0;
            r_Mem_Wdata   <= '0;
            r_Mem_Byte_En <= '0;
        end else begin
            r_Done <= 1'b0;
            case (r_State)
                S_IDLE: begin
                    if (i_Start) begin
                        if (!(w_Is_Load || w_Is_Store)) begin
                            r_Done       <= 1'b1;
                            r_Misaligned <= 1'b0;
                        end else if (w_Misaligned) begin
                            // Aborted before touching memory; load data untouched.
                            r_Done       <= 1'b1;
                            r_Misaligned <= 1'b1;
                        end else begin
                            r_State       <= S_REQ;
                            r_Busy        <= 1'b1;
                            r_Misaligned  <= 1'b0;
                            r_Mem_Req     <= 1'b1;
                            r_Mem_Write   <= w_Is_Store;
                            r_Mem_Addr    <= {i_Addr[XLEN-1:2], 2'b00};
                            r_Mem_Byte_En <= w_Byte_En;
                            r_Mem_Wdata   <= w_Wdata;
                            r_Size        <= w_Size;
                            r_Signed      <= w_Signed;
                            r_Off         <= i_Addr[1:0];
                        end
                    end
                end
                S_REQ: begin
                    if (mem.i_Mem_Ready) begin
                        r_Mem_Req <= 1'b0;
                        if (r_Mem_Write) begin
                            r_State <= S_IDLE;
                            r_Busy  <= 1'b0;
                            r_Done  <= 1'b1;
                        end else begin
                            r_State <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem.i_Mem_Rvalid) begin
                        r_Load_Data <= w_Load_Ext;
                        r_Done      <= 1'b1;
                        r_Busy      <= 1'b0;
                        r_State     <= S_IDLE;
                    end
                end
                default: r_State <= S_IDLE;
            endcase
        end
    end

    assign o_Busy            = r_Busy;
    assign o_Done            = r_Done;
    assign o_Load_Data       = r_Load_Data;
    assign o_Misaligned      = r_Misaligned;
    assign mem.o_Mem_Req     = r_Mem_Req;
    assign mem.o_Mem_Write   = r_Mem_Write;
    assign mem.o_Mem_Addr    = r_Mem_Addr;
    assign mem.o_Mem_Byte_En = r_Mem_Byte_En;
    assign mem.o_Mem_Wdata   = r_Mem_Wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed transactions driven on the falling
// edge, a transaction-level model of expected completions and requests, and
// a compare process that checks the DUT after every rising edge.
module tb_load_store_unit;

    logic        clk, rst_n;
    logic        i_Start;
    logic [4:0]  i_Load_Store_Type;
    logic [31:0] i_Addr, i_Store_Data;
    logic        o_Busy, o_Done, o_Misaligned;
    logic [31:0] o_Load_Data;

    load_store_unit_if #(.XLEN(32)) mem_if ();

    load_store_unit #(.XLEN(32)) dut (
        .i_Clk             (clk),
        .i_Reset_N         (rst_n),
        .i_Start           (i_Start),
        .i_Load_Store_Type (i_Load_Store_Type),
        .i_Addr            (i_Addr),
        .i_Store_Data      (i_Store_Data),
        .o_Busy            (o_Busy),
        .o_Done            (o_Done),
        .o_Load_Data       (o_Load_Data),
        .o_Misaligned      (o_Misaligned),
        .mem               (mem_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        bit          mis;
        bit          is_ld;
        logic [31:0] ld;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_ld = '0;
    bit          m_req_v = 0;
    bit          m_wr;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_en;

    function automatic int m_kind(input logic [4:0] t);
        if (t >= 5'd1 && t <= 5'd5) return 1;   // load
        if (t >= 5'd6 && t <= 5'd8) return 2;   // store
        return 0;
    endfunction

    function automatic int m_bytes(input logic [4:0] t);
        case (t)
            5'd1, 5'd4, 5'd6: return 1;
            5'd2, 5'd5, 5'd7: return 2;
            5'd3, 5'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit m_mis(input logic [4:0] t, input logic [31:0] a);
        int sz = m_bytes(t);
        return (sz > 1) && ((a % sz) != 0);
    endfunction

    function automatic logic [3:0] m_en_f(input logic [4:0] t, input logic [31:0] a);
        int sz = m_bytes(t);
        int lane = int'(a % 4);
        if (sz == 4) return 4'hF;
        return 4'((sz == 1 ? 1 : 3) << lane);
    endfunction

    function automatic logic [31:0] m_wd_f(input logic [4:0] t, input logic [31:0] d);
        int sz = m_bytes(t);
        if (sz == 1) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [4:0] t, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        int sz = m_bytes(t);
        if (sz == 1) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (t == 5'd1 && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2) begin
            v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (t == 5'd2 && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            q.delete();
            m_ld = '0;
        end
        if (o_Done) begin
            if (q.size() == 0) begin
                chk("unexpected done", 32'(o_Done), 32'd0);
            end else begin
                e = q.pop_front();
                chk("misaligned flag", 32'(o_Misaligned), 32'(e.mis));
                if (e.is_ld) m_ld = e.ld;
            end
        end
        chk("load_data held", o_Load_Data, m_ld);
        if (mem_if.o_Mem_Req) begin
            if (!m_req_v) begin
                chk("unexpected mem_req", 32'(mem_if.o_Mem_Req), 32'd0);
            end else begin
                chk("req addr", mem_if.o_Mem_Addr, m_addr);
                chk("req write", 32'(mem_if.o_Mem_Write), 32'(m_wr));
                chk("req byte_en", 32'(mem_if.o_Mem_Byte_En), 32'(m_en));
                if (m_wr) chk("req wdata", mem_if.o_Mem_Wdata, m_wd);
            end
        end
    end

    // ---------------- driver ----------------
    // Issues one instruction at a falling edge and plays the memory side.
    // rdy_dly = cycles the request waits for ready; pulse = fire a stray
    // i_Start during WAIT (delays rvalid by one cycle).
    task automatic txn(input string nm, input logic [4:0] t, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd, input int rdy_dly,
                       input int exp_lat, input logic [3:0] x_en, input logic [31:0] x_wd,
                       input logic [31:0] x_ld, input bit pulse);
        exp_t e;
        bit acc = 0, done = 0, rv_sent = 0, en_chk = 0;
        int lat = 0, rs = 0, wc = 0;
        e.mis   = m_mis(t, a);
        e.is_ld = (m_kind(t) == 1) && !e.mis;
        e.ld    = m_load(t, a, rd);
        q.push_back(e);
        m_req_v = (m_kind(t) != 0) && !e.mis;
        m_wr    = (m_kind(t) == 2);
        m_addr  = a & ~32'd3;
        m_en    = m_en_f(t, a);
        m_wd    = m_wd_f(t, d);
        i_Start = 1'b1; i_Load_Store_Type = t; i_Addr = a; i_Store_Data = d;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            lat++;
            i_Start = 1'b0;
            mem_if.i_Mem_Ready  = 1'b0;
            mem_if.i_Mem_Rvalid = 1'b0;
            mem_if.i_Mem_Rdata  = ~rd;
            if (o_Done) begin
                done = 1;
                break;
            end
            chk({nm, " busy"}, 32'(o_Busy), 32'd1);
            if (mem_if.o_Mem_Req) begin
                if (!en_chk) begin
                    chk({nm, " byte_en"}, 32'(mem_if.o_Mem_Byte_En), 32'(x_en));
                    if (m_wr) chk({nm, " wdata"}, mem_if.o_Mem_Wdata, x_wd);
                    en_chk = 1;
                end
                if (rs >= rdy_dly) begin
                    mem_if.i_Mem_Ready = 1'b1;
                    acc = 1;
                end
                rs++;
            end else if (acc && !rv_sent) begin
                if (pulse && wc == 0) begin
                    i_Start = 1'b1; i_Load_Store_Type = 5'd8;
                    i_Addr = 32'h500; i_Store_Data = 32'hFFFFFFFF;
                end else begin
                    mem_if.i_Mem_Rvalid = 1'b1;
                    mem_if.i_Mem_Rdata  = rd;
                    rv_sent = 1;
                end
                wc++;
            end
        end
        m_req_v = 0;
        chk({nm, " done seen"}, 32'(done), 32'd1);
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " busy at done"}, 32'(o_Busy), 32'd0);
        chk({nm, " load_data"}, o_Load_Data, x_ld);
    endtask

    initial begin
        rst_n = 1'b0;
        i_Start = 1'b0; i_Load_Store_Type = '0; i_Addr = '0; i_Store_Data = '0;
        mem_if.i_Mem_Ready = 1'b0; mem_if.i_Mem_Rvalid = 1'b0; mem_if.i_Mem_Rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(o_Busy), 32'd0);
        chk("reset done", 32'(o_Done), 32'd0);
        chk("reset misaligned", 32'(o_Misaligned), 32'd0);
        chk("reset load_data", o_Load_Data, 32'd0);
        chk("reset req", 32'(mem_if.o_Mem_Req), 32'd0);
        chk("reset addr", mem_if.o_Mem_Addr, 32'd0);
        chk("reset byte_en", 32'(mem_if.o_Mem_Byte_En), 32'd0);
        chk("reset wdata", mem_if.o_Mem_Wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        //   name        type  addr        data          rdata         rdy lat en     wdata         load_data    pulse
        txn("SW",        5'd8, 32'h100, 32'hDEADBEEF, 32'h0,        0,  2, 4'hF, 32'hDEADBEEF, 32'h0,        0);
        txn("SB slow",   5'd6, 32'h103, 32'h000000A5, 32'h0,        3,  5, 4'h8, 32'hA5A5A5A5, 32'h0,        0);
        txn("LB",        5'd1, 32'h202, 32'h0,        32'h12F45678, 0,  3, 4'h4, 32'h0,        32'hFFFFFFF4, 0);
        txn("LBU",       5'd4, 32'h202, 32'h0,        32'h12F45678, 0,  3, 4'h4, 32'h0,        32'h000000F4, 0);
        txn("LHU",       5'd5, 32'h202, 32'h0,        32'h12F45678, 0,  3, 4'hC, 32'h0,        32'h000012F4, 0);
        txn("LW mis",    5'd3, 32'h305, 32'h0,        32'h0,        0,  1, 4'h0, 32'h0,        32'h000012F4, 0);
        txn("SH mis",    5'd7, 32'h301, 32'h1234,     32'h0,        0,  1, 4'h0, 32'h0,        32'h000012F4, 0);
        txn("LH pulse",  5'd2, 32'h200, 32'h0,        32'h12348001, 0,  4, 4'h3, 32'h0,        32'hFFFF8001, 1);
        txn("NONE",      5'd0, 32'h40,  32'h0,        32'h0,        0,  1, 4'h0, 32'h0,        32'hFFFF8001, 0);
        txn("type15",    5'd15,32'h44,  32'h0,        32'h0,        0,  1, 4'h0, 32'h0,        32'hFFFF8001, 0);
        txn("LW slow",   5'd3, 32'h104, 32'h0,        32'hCAFEBABE, 1,  4, 4'hF, 32'h0,        32'hCAFEBABE, 0);
        txn("SH hi",     5'd7, 32'h102, 32'h1234ABCD, 32'h0,        0,  2, 4'hC, 32'hABCDABCD, 32'hCAFEBABE, 0);
        txn("LB pos",    5'd1, 32'h001, 32'h0,        32'h00007F00, 0,  3, 4'h2, 32'h0,        32'h0000007F, 0);
        txn("LH mis",    5'd2, 32'h203, 32'h0,        32'h0,        0,  1, 4'h0, 32'h0,        32'h0000007F, 0);
        repeat (3) @(negedge clk);

        // Reset while a load waits for read data.
        m_req_v = 1; m_wr = 0; m_addr = 32'h400; m_en = 4'hF; m_wd = '0;
        i_Start = 1'b1; i_Load_Store_Type = 5'd3; i_Addr = 32'h400;
        @(negedge clk);
        i_Start = 1'b0;
        chk("rst-test req", 32'(mem_if.o_Mem_Req), 32'd1);
        mem_if.i_Mem_Ready = 1'b1;
        @(negedge clk);
        mem_if.i_Mem_Ready = 1'b0;
        chk("rst-test busy in wait", 32'(o_Busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst-test busy", 32'(o_Busy), 32'd0);
        chk("rst-test req", 32'(mem_if.o_Mem_Req), 32'd0);
        chk("rst-test load_data", o_Load_Data, 32'd0);
        m_req_v = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_if.i_Mem_Rvalid = 1'b1; mem_if.i_Mem_Rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_if.i_Mem_Rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late rvalid done", 32'(o_Done), 32'd0);
            chk("late rvalid load_data", o_Load_Data, 32'd0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
